// File: rtl/fetch_stage.sv
// Dual-slot instruction fetch: PC sequencing, 1-cycle imem interface, one-entry skid buffer.
// Optional build macro FETCH_PERF_CNT_EN adds packet / stall performance counters.
module fetch_stage #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    FETCH_W     = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    fetch_en,
  input  logic                                    stall,
  input  logic                                    redirect_en,
  input  logic [ADDR_WIDTH-1:0]                   redirect_pc,
  output logic [FETCH_W-1:0]                      if_valid,
  output logic [FETCH_W-1:0][ADDR_WIDTH-1:0]      if_pc,
  output logic [FETCH_W-1:0][INSTR_WIDTH-1:0]     if_instr,
  output logic [ADDR_WIDTH-1:0]                   imem_addr0,
  output logic [ADDR_WIDTH-1:0]                   imem_addr1,
  output logic                                    imem_ren,
  input  logic [INSTR_WIDTH-1:0]                  imem_rdata0,
  input  logic [INSTR_WIDTH-1:0]                  imem_rdata1,
  input  logic [FETCH_W-1:0][ADDR_WIDTH-1:0]      imem_pc,
  input  logic                                    imem_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                             perf_pkts,
  output logic [31:0]                             perf_stall_cycles
`endif
);

  localparam logic [ADDR_WIDTH-1:0] WORD_BYTES   = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] FETCH_STRIDE = ADDR_WIDTH'(8);

  logic [ADDR_WIDTH-1:0]               pc_p0;
  logic                                skid_vld_p1;
  logic [FETCH_W-1:0][ADDR_WIDTH-1:0]  skid_pc_p1;
  logic [FETCH_W-1:0][INSTR_WIDTH-1:0] skid_instr_p1;

  // Stage 0: request generation
  assign imem_addr0 = pc_p0;
  assign imem_addr1 = pc_p0 + WORD_BYTES;
  assign imem_ren   = reset & fetch_en & ~stall & ~redirect_en & ~skid_vld_p1;

  // Stage 1: response capture into output packet or skid buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_p0       <= RESET_PC;
      skid_vld_p1 <= 1'b0;
      if_valid    <= '0;
      if_pc       <= '0;
      if_instr    <= '0;
    end else if (redirect_en) begin
      pc_p0       <= redirect_pc;
      skid_vld_p1 <= 1'b0;
      if_valid    <= '0;
    end else begin
      if (imem_ren)
        pc_p0 <= pc_p0 + FETCH_STRIDE;
      if (!stall) begin
        if (skid_vld_p1) begin
          // No request was issued while the skid was full, so no response competes here.
          if_valid    <= {FETCH_W{1'b1}};
          if_pc       <= skid_pc_p1;
          if_instr    <= skid_instr_p1;
          skid_vld_p1 <= 1'b0;
        end else begin
          if_valid <= {FETCH_W{imem_valid}};
          if (imem_valid) begin
            if_pc    <= imem_pc;
            if_instr <= {imem_rdata1, imem_rdata0};
          end
        end
      end else if (imem_valid) begin
        skid_vld_p1 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (stall && imem_valid && !redirect_en) begin
      skid_pc_p1    <= imem_pc;
      skid_instr_p1 <= {imem_rdata1, imem_rdata0};
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_pkts         <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if ((if_valid != '0) && !stall)
        perf_pkts <= perf_pkts + 32'd1;
      if (stall)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a 1-cycle synchronous imem model.
module tb_fetch_stage;

  logic             clk;
  logic             reset;
  logic             fetch_en;
  logic             stall;
  logic             redirect_en;
  logic [31:0]      redirect_pc;
  logic [1:0]       if_valid;
  logic [1:0][31:0] if_pc;
  logic [1:0][31:0] if_instr;
  logic [31:0]      imem_addr0;
  logic [31:0]      imem_addr1;
  logic             imem_ren;
  logic [31:0]      imem_rdata0;
  logic [31:0]      imem_rdata1;
  logic [1:0][31:0] imem_pc;
  logic             imem_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]      perf_pkts;
  logic [31:0]      perf_stall_cycles;
`endif

  int tests;
  int fails;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .imem_addr0  (imem_addr0),
    .imem_addr1  (imem_addr1),
    .imem_ren    (imem_ren),
    .imem_rdata0 (imem_rdata0),
    .imem_rdata1 (imem_rdata1),
    .imem_pc     (imem_pc),
    .imem_valid  (imem_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_pkts         (perf_pkts),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word k of memory holds (k+1)*0x11111111: 0x00->11111111, 0x04->22222222, ...
  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return ((addr >> 2) + 32'd1) * 32'h11111111;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_valid <= 1'b0;
    end else begin
      imem_valid <= imem_ren;
      if (imem_ren) begin
        imem_rdata0 <= word_at(imem_addr0);
        imem_rdata1 <= word_at(imem_addr1);
        imem_pc[0]  <= imem_addr0;
        imem_pc[1]  <= imem_addr1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    fetch_en    = 1'b0;
    stall       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    fetch_en    = 1'b1;
    stall       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (if_valid !== 2'b00) begin fails++; $display("FAIL reset_valid: got %b expected 00", if_valid); end
    tests++;
    if (if_pc !== 64'h0 || if_instr !== 64'h0) begin
      fails++; $display("FAIL reset_fields: pc=%h instr=%h expected all zero", if_pc, if_instr);
    end
    tests++;
    if (imem_ren !== 1'b0) begin fails++; $display("FAIL reset_ren: got %b expected 0", imem_ren); end
    tests++;
    if (imem_addr0 !== 32'h0 || imem_addr1 !== 32'h4) begin
      fails++; $display("FAIL reset_addr: got %h/%h expected 00000000/00000004", imem_addr0, imem_addr1);
    end
    reset = 1'b1;
  endtask

  task automatic test_stream();
    do_reset();
    fetch_en = 1'b1;
    #1;
    tests++;
    if (imem_ren !== 1'b1 || imem_addr0 !== 32'h0 || imem_addr1 !== 32'h4) begin
      fails++; $display("FAIL stream_first_req: ren=%b addr=%h/%h expected 1 00000000/00000004", imem_ren, imem_addr0, imem_addr1);
    end
    tick();
    tests++;
    if (if_valid !== 2'b00) begin fails++; $display("FAIL stream_latency: valid=%b expected 00 one edge after request", if_valid); end
    tick();
    tests++;
    if (if_valid !== 2'b11 || if_pc[0] !== 32'h0 || if_pc[1] !== 32'h4 ||
        if_instr[0] !== 32'h11111111 || if_instr[1] !== 32'h22222222) begin
      fails++; $display("FAIL stream_pkt0: valid=%b pc=%h/%h instr=%h/%h expected 11 00000000/00000004 11111111/22222222",
                        if_valid, if_pc[0], if_pc[1], if_instr[0], if_instr[1]);
    end
    for (int k = 1; k < 4; k++) begin
      logic [31:0] p;
      p = 32'(k * 8);
      tick();
      tests++;
      if (if_valid !== 2'b11 || if_pc[0] !== p || if_pc[1] !== p + 32'd4 ||
          if_instr[0] !== word_at(p) || if_instr[1] !== word_at(p + 32'd4)) begin
        fails++; $display("FAIL stream_pkt%0d: valid=%b pc=%h/%h instr=%h/%h expected 11 %h/%h %h/%h", k,
                          if_valid, if_pc[0], if_pc[1], if_instr[0], if_instr[1], p, p + 32'd4, word_at(p), word_at(p + 32'd4));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    fetch_en = 1'b1;
    tick();
    tick();
    stall = 1'b1;
    tick();
    tests++;
    if (if_valid !== 2'b11 || if_pc[0] !== 32'h0 || if_instr[1] !== 32'h22222222 || imem_ren !== 1'b0) begin
      fails++; $display("FAIL stall_hold1: valid=%b pc0=%h instr1=%h ren=%b expected 11 00000000 22222222 0",
                        if_valid, if_pc[0], if_instr[1], imem_ren);
    end
    tick();
    tests++;
    if (if_valid !== 2'b11 || if_pc[0] !== 32'h0 || if_instr[0] !== 32'h11111111) begin
      fails++; $display("FAIL stall_hold2: valid=%b pc0=%h instr0=%h expected 11 00000000 11111111", if_valid, if_pc[0], if_instr[0]);
    end
`ifdef FETCH_PERF_CNT_EN
    tests++;
    if (perf_stall_cycles !== 32'd2 || perf_pkts !== 32'd0) begin
      fails++; $display("FAIL perf_counts: stall_cycles=%0d pkts=%0d expected 2 0", perf_stall_cycles, perf_pkts);
    end
`endif
    stall = 1'b0;
    #1;
    tests++;
    if (imem_ren !== 1'b0) begin fails++; $display("FAIL stall_skid_blocks_ren: got %b expected 0", imem_ren); end
    tick();
    tests++;
    if (if_valid !== 2'b11 || if_pc[0] !== 32'h8 || if_pc[1] !== 32'hC ||
        if_instr[0] !== 32'h33333333 || if_instr[1] !== 32'h44444444) begin
      fails++; $display("FAIL stall_skid_pkt: valid=%b pc=%h/%h instr=%h/%h expected 11 00000008/0000000c 33333333/44444444",
                        if_valid, if_pc[0], if_pc[1], if_instr[0], if_instr[1]);
    end
    tick();
    tick();
    tests++;
    if (if_valid !== 2'b11 || if_pc[0] !== 32'h10 || if_pc[1] !== 32'h14 || if_instr[0] !== 32'h55555555) begin
      fails++; $display("FAIL stall_resume_pkt: valid=%b pc=%h/%h instr0=%h expected 11 00000010/00000014 55555555",
                        if_valid, if_pc[0], if_pc[1], if_instr[0]);
    end
    tick();
    tests++;
    if (if_valid !== 2'b11 || if_pc[0] !== 32'h18 || if_instr[1] !== 32'h88888888) begin
      fails++; $display("FAIL stall_next_pkt: valid=%b pc0=%h instr1=%h expected 11 00000018 88888888", if_valid, if_pc[0], if_instr[1]);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    fetch_en = 1'b1;
    tick();
    tick();
    redirect_en = 1'b1;
    redirect_pc = 32'h8;
    #1;
    tests++;
    if (imem_ren !== 1'b0) begin fails++; $display("FAIL redirect_no_req: ren=%b expected 0", imem_ren); end
    tick();
    redirect_en = 1'b0;
    #1;
    tests++;
    if (if_valid !== 2'b00 || imem_addr0 !== 32'h8 || imem_ren !== 1'b1) begin
      fails++; $display("FAIL redirect_squash: valid=%b addr0=%h ren=%b expected 00 00000008 1", if_valid, imem_addr0, imem_ren);
    end
    tick();
    tests++;
    if (if_valid !== 2'b00) begin fails++; $display("FAIL redirect_drop_inflight: valid=%b expected 00", if_valid); end
    tick();
    tests++;
    if (if_valid !== 2'b11 || if_pc[0] !== 32'h8 || if_pc[1] !== 32'hC ||
        if_instr[0] !== 32'h33333333 || if_instr[1] !== 32'h44444444) begin
      fails++; $display("FAIL redirect_pkt: valid=%b pc=%h/%h instr=%h/%h expected 11 00000008/0000000c 33333333/44444444",
                        if_valid, if_pc[0], if_pc[1], if_instr[0], if_instr[1]);
    end
    // Target with bit 2 set: both slots still valid, fetched from target and target+4.
    redirect_en = 1'b1;
    redirect_pc = 32'h14;
    tick();
    redirect_en = 1'b0;
    tick();
    tick();
    tests++;
    if (if_valid !== 2'b11 || if_pc[0] !== 32'h14 || if_pc[1] !== 32'h18 ||
        if_instr[0] !== 32'h66666666 || if_instr[1] !== 32'h77777777) begin
      fails++; $display("FAIL redirect_odd_pkt: valid=%b pc=%h/%h instr=%h/%h expected 11 00000014/00000018 66666666/77777777",
                        if_valid, if_pc[0], if_pc[1], if_instr[0], if_instr[1]);
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    fetch_en = 1'b1;
    tick();
    tick();
    stall       = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 32'h8;
    tick();
    redirect_en = 1'b0;
    tests++;
    if (if_valid !== 2'b00) begin fails++; $display("FAIL redir_stall_wins: valid=%b expected 00", if_valid); end
    tick();
    stall = 1'b0;
    #1;
    tests++;
    if (imem_ren !== 1'b1 || imem_addr0 !== 32'h8) begin
      fails++; $display("FAIL redir_stall_req: ren=%b addr0=%h expected 1 00000008", imem_ren, imem_addr0);
    end
    tick();
    tick();
    tests++;
    if (if_valid !== 2'b11 || if_pc[0] !== 32'h8 || if_instr[0] !== 32'h33333333 || if_instr[1] !== 32'h44444444) begin
      fails++; $display("FAIL redir_stall_pkt: valid=%b pc0=%h instr=%h/%h expected 11 00000008 33333333/44444444",
                        if_valid, if_pc[0], if_instr[0], if_instr[1]);
    end
  endtask

  task automatic test_fetch_en();
    do_reset();
    fetch_en = 1'b1;
    tick();
    tick();
    fetch_en = 1'b0;
    #1;
    tests++;
    if (imem_ren !== 1'b0) begin fails++; $display("FAIL fetch_en_off_ren: got %b expected 0", imem_ren); end
    tick();
    fetch_en = 1'b1;
    #1;
    tests++;
    if (if_valid !== 2'b11 || if_pc[0] !== 32'h8 || imem_addr0 !== 32'h10) begin
      fails++; $display("FAIL fetch_en_inflight: valid=%b pc0=%h addr0=%h expected 11 00000008 00000010", if_valid, if_pc[0], imem_addr0);
    end
    tick();
    tests++;
    if (if_valid !== 2'b00) begin fails++; $display("FAIL fetch_en_bubble: valid=%b expected 00", if_valid); end
    tick();
    tests++;
    if (if_valid !== 2'b11 || if_pc[0] !== 32'h10 || if_pc[1] !== 32'h14 || if_instr[0] !== 32'h55555555) begin
      fails++; $display("FAIL fetch_en_resume: valid=%b pc=%h/%h instr0=%h expected 11 00000010/00000014 55555555",
                        if_valid, if_pc[0], if_pc[1], if_instr[0]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    fetch_en = 1'b1;
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (if_valid !== 2'b00 || if_pc !== 64'h0 || imem_ren !== 1'b0 || imem_addr0 !== 32'h0) begin
      fails++; $display("FAIL async_reset: valid=%b pc=%h ren=%b addr0=%h expected 00 0 0 00000000",
                        if_valid, if_pc, imem_ren, imem_addr0);
    end
    #2;
    reset = 1'b1;
    tick();
    tests++;
    if (if_valid !== 2'b00) begin fails++; $display("FAIL async_restart_latency: valid=%b expected 00", if_valid); end
    tick();
    tests++;
    if (if_valid !== 2'b11 || if_pc[0] !== 32'h0 || if_pc[1] !== 32'h4 || if_instr[0] !== 32'h11111111) begin
      fails++; $display("FAIL async_restart_pkt: valid=%b pc=%h/%h instr0=%h expected 11 00000000/00000004 11111111",
                        if_valid, if_pc[0], if_pc[1], if_instr[0]);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_fetch_en();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
